// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: default word/register-file sizes and the
// clear-sequencer state encoding used by the register file.
package cpu_pkg;

   localparam int word_size = 8;
   localparam int reg_size  = 4;

   typedef logic [word_size-1:0]         word;
   typedef logic [$clog2(reg_size)-1:0]  regAddr;

   typedef enum logic [0:0] {
      CLR_IDLE  = 1'b0,
      CLR_SWEEP = 1'b1
   } clr_state_e;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Bulk-clear sequencer: on a clear request, walks every register index once,
// overriding the array write path with a zero write per edge.
module reg_file_clr_fsm
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   clr_state_e    state;
   logic [AW-1:0] cnt;
   logic          busy;

   // Sweep state, index counter and registered busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLR_IDLE;
         cnt   <= {AW{1'b0}};
         busy  <= 1'b0;
      end else begin
         case (state)
            CLR_IDLE: begin
               if (clr_req) begin
                  state <= CLR_SWEEP;
                  cnt   <= {AW{1'b0}};
                  busy  <= 1'b1;
               end else begin
                  busy  <= 1'b0;
               end
            end
            CLR_SWEEP: begin
               if (cnt == LAST) begin
                  state <= CLR_IDLE;
                  cnt   <= {AW{1'b0}};
                  busy  <= 1'b0;
               end else begin
                  cnt   <= cnt + {{(AW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state <= CLR_IDLE;
               cnt   <= {AW{1'b0}};
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy = busy;
   assign clr_we   = (state == CLR_SWEEP);
   assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD registered read ports, two prioritised write ports,
// optional zero register and bulk clear. Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file_mp
   import cpu_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 0,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   input  logic [1:0]           wr_en,
   input  logic [2*AW-1:0]      wr_addr,
   input  logic [2*WIDTH-1:0]   wr_data,
   input  logic                 clr_req,
   output logic                 clr_busy
);

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   logic [1:0]       wr_ok;

   function automatic logic in_range(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_W);
   endfunction

   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == {AW{1'b0}});
   endfunction

   reg_file_clr_fsm #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // A user write is accepted only outside the sweep and to a writable address
   always_comb begin
      wr_ok = 2'b00;
      for (int k = 0; k < 2; k++) begin
         if (wr_en[k] && !clr_we && in_range(wr_addr[k*AW +: AW]) &&
             !is_zero_reg(wr_addr[k*AW +: AW])) begin
            wr_ok[k] = 1'b1;
         end else begin
            wr_ok[k] = 1'b0;
         end
      end
   end

   // Storage array; port 1 is applied last so it wins a same-address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= {WIDTH{1'b0}};
         end
      end else if (clr_we) begin
         regs[clr_addr] <= {WIDTH{1'b0}};
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (wr_ok[k]) begin
               regs[wr_addr[k*AW +: AW]] <= wr_data[k*WIDTH +: WIDTH];
            end
         end
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] rd_next;
      logic [WIDTH-1:0] rd_q;

      assign ra = rd_addr[g*AW +: AW];

      // Read-port next value; the zero register overrides any forwarding
      always_comb begin
         rd_next = {WIDTH{1'b0}};
         if (!in_range(ra) || is_zero_reg(ra)) begin
            rd_next = {WIDTH{1'b0}};
`ifdef REG_FILE_BYPASS_EN
         end else if (wr_ok[1] && (wr_addr[AW +: AW] == ra)) begin
            rd_next = wr_data[WIDTH +: WIDTH];
         end else if (wr_ok[0] && (wr_addr[0 +: AW] == ra)) begin
            rd_next = wr_data[0 +: WIDTH];
`endif
         end else begin
            rd_next = regs[ra];
         end
      end

      // Registered read data, one cycle after the address is sampled
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_q <= {WIDTH{1'b0}};
         end else begin
            rd_q <= rd_next;
         end
      end

      assign rd_data[g*WIDTH +: WIDTH] = rd_q;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table, hand-written clear and
// reset sequences, then random traffic against a behavioural model of two configurations.
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rd_addr;
   logic [15:0] rd_data;
   logic [5:0]  rd_addr_z;
   logic [23:0] rd_data_z;
   logic [1:0]  wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        clr_req;
   logic        clr_busy;
   logic        clr_busy_z;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   reg_file_mp #(.WIDTH(8), .DEPTH(4), .NRD(2), .ZERO_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_req(clr_req), .clr_busy(clr_busy)
   );

   reg_file_mp #(.WIDTH(8), .DEPTH(3), .NRD(3), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_z), .rd_data(rd_data_z),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_req(clr_req), .clr_busy(clr_busy_z)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: instance 0 = dut, instance 1 = dut_z
   int         dep [2] = '{4, 3};
   bit         zr  [2] = '{1'b0, 1'b1};
   int         nrd [2] = '{2, 3};
   logic [7:0] m      [2][4];
   bit         busy   [2];
   int         idx    [2];
   logic [7:0] exp_rd [2][3];

   typedef struct {
      logic [1:0] we;
      logic [1:0] wa0;
      logic [7:0] wd0;
      logic [1:0] wa1;
      logic [7:0] wd1;
      logic [1:0] ra;
      logic [7:0] exp;
      logic [7:0] exp_byp;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int raddr(input int inst, input int p);
      if (inst == 0) return int'(rd_addr[p*2 +: 2]);
      return int'(rd_addr_z[p*2 +: 2]);
   endfunction

   function automatic int wa(input int k);
      return int'(wr_addr[k*2 +: 2]);
   endfunction

   function automatic logic [7:0] wd(input int k);
      return wr_data[k*8 +: 8];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         busy[i] = 1'b0;
         idx[i]  = 0;
         for (int a = 0; a < 4; a++) m[i][a] = 8'h00;
         for (int p = 0; p < 3; p++) exp_rd[i][p] = 8'h00;
      end
   endtask

   // Applies one clock edge to the model using the inputs present at that edge
   task automatic model_edge();
      int a;
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < nrd[i]; p++) begin
            a = raddr(i, p);
            if (a >= dep[i] || (zr[i] && a == 0))                   exp_rd[i][p] = 8'h00;
            else if (BYP && !busy[i] && wr_en[1] && wa(1) == a)    exp_rd[i][p] = wd(1);
            else if (BYP && !busy[i] && wr_en[0] && wa(0) == a)    exp_rd[i][p] = wd(0);
            else                                                    exp_rd[i][p] = m[i][a];
         end
         if (busy[i]) begin
            m[i][idx[i]] = 8'h00;
            idx[i]++;
            if (idx[i] == dep[i]) busy[i] = 1'b0;
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (wr_en[k] && wa(k) < dep[i] && !(zr[i] && wa(k) == 0)) m[i][wa(k)] = wd(k);
            end
            if (clr_req) begin
               busy[i] = 1'b1;
               idx[i]  = 0;
            end
         end
      end
   endtask

   task automatic model_check();
      for (int p = 0; p < 2; p++) check($sformatf("model rd dut.%0d", p), 32'(rd_data[p*8 +: 8]), 32'(exp_rd[0][p]));
      for (int p = 0; p < 3; p++) check($sformatf("model rd dut_z.%0d", p), 32'(rd_data_z[p*8 +: 8]), 32'(exp_rd[1][p]));
      check("model clr_busy dut", 32'(clr_busy), 32'(busy[0]));
      check("model clr_busy dut_z", 32'(clr_busy_z), 32'(busy[1]));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      model_check();
   endtask

   task automatic set_idle();
      wr_en   = 2'b00;
      clr_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rd_data"}, 32'(rd_data), 32'h0);
      check({tag, " rd_data_z"}, 32'(rd_data_z), 32'h0);
      check({tag, " clr_busy"}, 32'(clr_busy), 32'h0);
      check({tag, " clr_busy_z"}, 32'(clr_busy_z), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt_a;
      int cnt_b;
      logic [7:0] e;

      tbl[0] = '{we:2'b01, wa0:2'd2, wd0:8'hA5, wa1:2'd0, wd1:8'h00, ra:2'd0, exp:8'h00, exp_byp:8'h00};
      tbl[1] = '{we:2'b00, wa0:2'd0, wd0:8'h00, wa1:2'd0, wd1:8'h00, ra:2'd2, exp:8'hA5, exp_byp:8'hA5};
      tbl[2] = '{we:2'b11, wa0:2'd1, wd0:8'h11, wa1:2'd1, wd1:8'h22, ra:2'd1, exp:8'h00, exp_byp:8'h22};
      tbl[3] = '{we:2'b00, wa0:2'd0, wd0:8'h00, wa1:2'd0, wd1:8'h00, ra:2'd1, exp:8'h22, exp_byp:8'h22};
      tbl[4] = '{we:2'b01, wa0:2'd3, wd0:8'h0F, wa1:2'd0, wd1:8'h00, ra:2'd2, exp:8'hA5, exp_byp:8'hA5};
      tbl[5] = '{we:2'b10, wa0:2'd0, wd0:8'h00, wa1:2'd3, wd1:8'hF0, ra:2'd3, exp:8'h0F, exp_byp:8'hF0};
      tbl[6] = '{we:2'b00, wa0:2'd0, wd0:8'h00, wa1:2'd0, wd1:8'h00, ra:2'd3, exp:8'hF0, exp_byp:8'hF0};

      rst_n     = 1'b0;
      rd_addr   = 4'h0;
      rd_addr_z = 6'h0;
      wr_addr   = 4'h0;
      wr_data   = 16'h0;
      set_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("initial reset");
      rst_n = 1'b1;

      // Directed table: write/read, collision, same-cycle read/write
      foreach (tbl[i]) begin
         wr_en   = tbl[i].we;
         wr_addr = {tbl[i].wa1, tbl[i].wa0};
         wr_data = {tbl[i].wd1, tbl[i].wd0};
         rd_addr = {tbl[i].ra, tbl[i].ra};
         step();
         e = BYP ? tbl[i].exp_byp : tbl[i].exp;
         check($sformatf("vec%0d port0", i), 32'(rd_data[7:0]), 32'(e));
         check($sformatf("vec%0d port1", i), 32'(rd_data[15:8]), 32'(e));
      end

      // Zero register: both ports write r0 on dut_z
      wr_en     = 2'b11;
      wr_addr   = 4'b0000;
      wr_data   = 16'h5555;
      rd_addr   = 4'h0;
      rd_addr_z = 6'h0;
      step();
      check("zero_reg same cycle", 32'(rd_data_z), 32'h0);
      set_idle();
      step();
      check("zero_reg next cycle", 32'(rd_data_z), 32'h0);
      check("non-zero-reg r0 written", 32'(rd_data[7:0]), 32'h55);

      // Clear: fill with FF, pulse clear, attempt writes during the sweep
      wr_en = 2'b11; wr_addr = {2'd1, 2'd0}; wr_data = 16'hFFFF; step();
      wr_addr = {2'd3, 2'd2}; step();
      cnt_a = 0;
      cnt_b = 0;
      for (int s = 0; s < 8; s++) begin
         clr_req = (s == 0 || s == 2);
         wr_en   = (s == 2) ? 2'b01 : 2'b00;
         wr_addr = 4'b0000;
         wr_data = 16'h0077;
         rd_addr = 4'h0;
         step();
         if (clr_busy)   cnt_a++;
         if (clr_busy_z) cnt_b++;
      end
      check("clr_busy cycles dut", 32'(cnt_a), 32'd4);
      check("clr_busy cycles dut_z", 32'(cnt_b), 32'd3);
      set_idle();
      for (int a = 0; a < 4; a++) begin
         rd_addr = {2'(a), 2'(a)};
         step();
         check($sformatf("after clear r%0d", a), 32'(rd_data), 32'h0);
      end

      // Reset in the middle of a sweep
      wr_en = 2'b11; wr_addr = {2'd2, 2'd1}; wr_data = 16'h3C5A; step();
      set_idle();
      clr_req = 1'b1; step();
      clr_req = 1'b0; step();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid-sweep reset");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd_addr   = {2'(a), 2'(a)};
         rd_addr_z = {2'(a), 2'(a), 2'(a)};
         step();
         check($sformatf("after reset r%0d", a), 32'(rd_data), 32'h0);
      end

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         wr_en     = 2'($urandom_range(0, 3));
         wr_addr   = 4'($urandom);
         wr_data   = 16'($urandom);
         rd_addr   = 4'($urandom);
         rd_addr_z = 6'($urandom);
         clr_req   = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
